// File: rtl/spi_slave_burst_ctrl.sv
// spi_slave_burst_ctrl: SPI slave command sequencer with lane-scaled field counters,
// auto-incrementing/wrapping burst addresses, sticky overrun/underrun flags and status readback.
module spi_slave_burst_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sclk,
  input  logic                  sys_rstn,
  input  logic                  cs,
  input  logic [1:0]            lane_mode,
  input  logic [7:0]            dummy_cycles,
  input  logic [15:0]           wrap_length,
  output logic                  pad_dir,
  output logic [1:0]            pad_lanes,
  output logic [7:0]            rx_counter,
  output logic                  rx_counter_upd,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_data_valid,
  output logic [7:0]            tx_counter,
  output logic                  tx_counter_upd,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_data_valid,
  input  logic                  tx_done,
  output logic                  ctrl_rd_wr,
  output logic [ADDR_WIDTH-1:0] ctrl_addr,
  output logic                  ctrl_addr_valid,
  output logic [DATA_WIDTH-1:0] ctrl_data_rx,
  output logic                  ctrl_data_rx_valid,
  input  logic                  ctrl_data_rx_ready,
  input  logic [DATA_WIDTH-1:0] ctrl_data_tx,
  input  logic                  ctrl_data_tx_valid,
  output logic                  ctrl_data_tx_ready,
  output logic                  cmd_error
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int XW = ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH;
  localparam logic [7:0] OP_WRITE = 8'h02, OP_READ = 8'h03, OP_FAST = 8'h0B, OP_STAT = 8'h05;

  typedef enum logic [2:0] {CMD, ADDR, DUMMY, DATA_RX, DATA_TX, STAT_TX, ERROR} state_t;
  state_t state, next;

  logic fast, load_pend, ovr, udr, wrap_en, tx_load, stat_load, beat, entering;
  logic [7:0] op;
  logic [XW-1:0] rx_ext;
  logic [31:0] mask32;
  logic [ADDR_WIDTH-1:0] mask, inc, addr_next;

  function automatic logic [7:0] field_cnt(input int bits, input logic [1:0] lanes);
    return 8'((bits >> (lanes == 2'b01 ? 1 : lanes == 2'b10 ? 2 : 0)) - 1);
  endfunction

  assign op = rx_data[7:0];
  assign rx_ext = XW'(rx_data);
  assign wrap_en = wrap_length != 16'd0 && (wrap_length & (wrap_length - 16'd1)) == 16'd0;
  assign mask32 = 32'(wrap_length) * 32'(BYTES) - 32'd1;
  assign mask = ADDR_WIDTH'(mask32);
  assign inc = ctrl_addr + ADDR_WIDTH'(BYTES);
  assign addr_next = wrap_en ? (ctrl_addr & ~mask) | (inc & mask) : inc;

  assign pad_dir = state == DATA_TX || state == STAT_TX;
  assign cmd_error = state == ERROR;
  assign ctrl_data_rx = ctrl_data_rx_valid ? rx_data : '0;
  assign tx_load = state == DATA_TX && load_pend && !cs;
  assign stat_load = state == STAT_TX && load_pend && !cs;
  assign beat = ctrl_data_rx_valid || tx_load;
  assign entering = (next == DATA_TX || next == STAT_TX) && next != state;

  always_ff @(posedge sclk or negedge sys_rstn)
    if (!sys_rstn) state <= CMD;
    else state <= next;

  // rx_counter describes the field that follows the one being accepted now
  always_comb begin
    next = state;
    rx_counter_upd = 1'b0;
    ctrl_data_rx_valid = 1'b0;
    if (cs) next = CMD;
    else begin
      case (state)
        CMD:     if (rx_data_valid) next = (op == OP_WRITE || op == OP_READ || op == OP_FAST) ? ADDR :
                                           op == OP_STAT ? STAT_TX : ERROR;
        ADDR:    if (rx_data_valid) next = !ctrl_rd_wr ? DATA_RX :
                                           (fast && dummy_cycles != 8'd0) ? DUMMY : DATA_TX;
        DUMMY:   if (rx_data_valid) next = DATA_TX;
        STAT_TX: if (tx_done) next = CMD;
        default: ;
      endcase
      rx_counter_upd = rx_data_valid && state != DATA_TX && state != STAT_TX;
      ctrl_data_rx_valid = rx_data_valid && state == DATA_RX;
    end
    rx_counter = next == ADDR ? field_cnt(ADDR_WIDTH, pad_lanes) :
                 next == DUMMY ? dummy_cycles - 8'd1 :
                 next == DATA_RX ? field_cnt(DATA_WIDTH, pad_lanes) : field_cnt(8, pad_lanes);
  end

  always_ff @(posedge sclk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      pad_lanes <= '0;
      tx_counter <= '0;
      tx_counter_upd <= 1'b0;
      tx_data <= '0;
      tx_data_valid <= 1'b0;
      ctrl_rd_wr <= 1'b0;
      ctrl_addr <= '0;
      ctrl_addr_valid <= 1'b0;
      ctrl_data_tx_ready <= 1'b0;
      fast <= 1'b0;
      load_pend <= 1'b0;
      ovr <= 1'b0;
      udr <= 1'b0;
    end else begin
      ctrl_addr_valid <= 1'b0;
      tx_data_valid <= 1'b0;
      tx_counter_upd <= 1'b0;
      ctrl_data_tx_ready <= 1'b0;
      if (state == CMD) pad_lanes <= lane_mode;
      if (cs) begin
        tx_data <= '0;
        ctrl_addr <= '0;
        ctrl_rd_wr <= 1'b0;
        fast <= 1'b0;
        load_pend <= 1'b0;
      end else begin
        load_pend <= entering || (load_pend && !tx_load && !stat_load) || (state == DATA_TX && tx_done);
        if (state == CMD && rx_data_valid) begin
          ctrl_rd_wr <= op == OP_READ || op == OP_FAST;
          fast <= op == OP_FAST;
        end
        if (state == ADDR && rx_data_valid) begin
          ctrl_addr <= rx_ext[ADDR_WIDTH-1:0];
          ctrl_addr_valid <= 1'b1;
        end
        // address is advanced right after each beat so it is ready for the next one
        if (beat) begin
          ctrl_addr <= addr_next;
          ctrl_addr_valid <= 1'b1;
        end
        if (ctrl_data_rx_valid && !ctrl_data_rx_ready) ovr <= 1'b1;
        if (tx_load) begin
          tx_data <= ctrl_data_tx_valid ? ctrl_data_tx : '0;
          tx_counter <= field_cnt(DATA_WIDTH, pad_lanes);
          tx_data_valid <= 1'b1;
          tx_counter_upd <= 1'b1;
          ctrl_data_tx_ready <= 1'b1;
          if (!ctrl_data_tx_valid) udr <= 1'b1;
        end
        if (stat_load) begin
          tx_data <= DATA_WIDTH'({6'b0, udr, ovr}) << (DATA_WIDTH - 8);
          tx_counter <= field_cnt(8, pad_lanes);
          tx_data_valid <= 1'b1;
          tx_counter_upd <= 1'b1;
        end
        if (state == STAT_TX && tx_done) begin
          ovr <= 1'b0;
          udr <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_burst_ctrl.sv
// tb_spi_slave_burst_ctrl: directed and randomized bursts checked against an arithmetic
// model of burst addresses, lane-scaled counters and sticky status flags.
module tb_spi_slave_burst_ctrl;
  localparam int AW = 32, DW = 32;

  logic sclk = 0, sys_rstn = 1, cs = 1;
  logic [1:0] lane_mode = 0;
  logic [7:0] dummy_cycles = 0;
  logic [15:0] wrap_length = 0;
  logic [DW-1:0] rx_data = 0, ctrl_data_tx = 0;
  logic rx_data_valid = 0, tx_done = 0, ctrl_data_rx_ready = 1, ctrl_data_tx_valid = 0;
  logic pad_dir, rx_counter_upd, tx_counter_upd, tx_data_valid, ctrl_rd_wr, ctrl_addr_valid;
  logic ctrl_data_rx_valid, ctrl_data_tx_ready, cmd_error;
  logic [1:0] pad_lanes;
  logic [7:0] rx_counter, tx_counter;
  logic [DW-1:0] tx_data, ctrl_data_rx;
  logic [AW-1:0] ctrl_addr;

  int checks = 0, errors = 0;
  logic m_ovr = 0, m_udr = 0;
  logic [15:0] wraps [7] = '{16'd0, 16'd2, 16'd4, 16'd8, 16'd3, 16'd6, 16'd16};

  always #5 sclk = ~sclk;

  spi_slave_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .sclk(sclk), .sys_rstn(sys_rstn), .cs(cs), .lane_mode(lane_mode),
    .dummy_cycles(dummy_cycles), .wrap_length(wrap_length), .pad_dir(pad_dir),
    .pad_lanes(pad_lanes), .rx_counter(rx_counter), .rx_counter_upd(rx_counter_upd),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .tx_counter(tx_counter),
    .tx_counter_upd(tx_counter_upd), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .tx_done(tx_done), .ctrl_rd_wr(ctrl_rd_wr), .ctrl_addr(ctrl_addr),
    .ctrl_addr_valid(ctrl_addr_valid), .ctrl_data_rx(ctrl_data_rx),
    .ctrl_data_rx_valid(ctrl_data_rx_valid), .ctrl_data_rx_ready(ctrl_data_rx_ready),
    .ctrl_data_tx(ctrl_data_tx), .ctrl_data_tx_valid(ctrl_data_tx_valid),
    .ctrl_data_tx_ready(ctrl_data_tx_ready), .cmd_error(cmd_error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge sclk);
  endtask

  function automatic int lanes_of(input logic [1:0] m);
    return m == 2'b01 ? 2 : m == 2'b10 ? 4 : 1;
  endfunction

  // next beat address: stays inside an aligned window of wrap*bytes when wrap is a power of two
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [15:0] w);
    logic [63:0] span, base, a64;
    if (w == 16'd0 || $countones(w) != 1) return a + 32'(DW / 8);
    a64 = {32'b0, a};
    span = 64'(w) * 64'(DW / 8);
    base = a64 - (a64 % span);
    return 32'(base + (a64 - base + 64'(DW / 8)) % span);
  endfunction

  task automatic start_txn(input logic [1:0] lm);
    cs = 1; lane_mode = lm; tick();
    cs = 0; tick();
    chk("idle_pad_lanes", pad_lanes, lm);
    chk("idle_rx_counter", rx_counter, 8 / lanes_of(lm) - 1);
  endtask

  task automatic end_txn;
    cs = 1; tick();
    chk("cs_tx_data", tx_data, 0);
    chk("cs_addr", ctrl_addr, 0);
    chk("cs_pad_dir", pad_dir, 0);
    chk("cs_rd_wr", ctrl_rd_wr, 0);
  endtask

  task automatic run_burst(input logic [7:0] op, input logic [1:0] lm, input logic [31:0] addr,
                           input int beats, input logic [15:0] wrap, input logic [7:0] dummy,
                           input logic [7:0] deny);
    int l = lanes_of(lm);
    logic rd = op != 8'h02;
    logic has_dummy = op == 8'h0B && dummy != 8'd0;
    logic [31:0] a = addr, d;
    dummy_cycles = dummy; wrap_length = wrap;
    start_txn(lm);
    rx_data = {24'b0, op}; rx_data_valid = 1; #1;
    chk("op_rx_counter", rx_counter, AW / l - 1);
    chk("op_upd", rx_counter_upd, 1);
    tick(); rx_data_valid = 0;
    rx_data = addr; rx_data_valid = 1; #1;
    if (!rd) chk("addr_next_cnt_wr", rx_counter, DW / l - 1);
    if (has_dummy) chk("addr_next_cnt_dummy", rx_counter, dummy - 8'd1);
    tick(); rx_data_valid = 0;
    chk("addr_latch", ctrl_addr, addr);
    chk("addr_valid", ctrl_addr_valid, 1);
    chk("rd_wr", ctrl_rd_wr, rd);
    if (has_dummy) begin
      repeat (2) tick();
      chk("dummy_rx_counter", rx_counter, dummy - 8'd1);
      chk("dummy_pad_dir", pad_dir, 0);
      rx_data = $urandom; rx_data_valid = 1; tick(); rx_data_valid = 0;
    end
    for (int k = 0; k < beats; k++) begin
      if (!rd) begin
        repeat ($urandom_range(0, 2)) tick();
        d = $urandom; rx_data = d; rx_data_valid = 1; ctrl_data_rx_ready = !deny[k]; #1;
        chk("wr_strobe", ctrl_data_rx_valid, 1);
        chk("wr_data", ctrl_data_rx, d);
        chk("wr_addr", ctrl_addr, a);
        chk("wr_rx_counter", rx_counter, DW / l - 1);
        if (deny[k]) m_ovr = 1;
        tick(); rx_data_valid = 0; ctrl_data_rx_ready = 1;
        chk("wr_addr_pulse", ctrl_addr_valid, 1);
      end else begin
        chk("rd_pad_dir", pad_dir, 1);
        chk("rd_addr", ctrl_addr, a);
        d = $urandom; ctrl_data_tx = d; ctrl_data_tx_valid = !deny[k];
        tick(); ctrl_data_tx_valid = 0;
        if (deny[k]) m_udr = 1;
        chk("rd_tx_data", tx_data, deny[k] ? 32'd0 : d);
        chk("rd_tx_valid", tx_data_valid, 1);
        chk("rd_tx_upd", tx_counter_upd, 1);
        chk("rd_tx_counter", tx_counter, DW / l - 1);
        chk("rd_tx_ready", ctrl_data_tx_ready, 1);
        chk("rd_addr_pulse", ctrl_addr_valid, 1);
        repeat ($urandom_range(0, 2)) tick();
        tx_done = 1; tick(); tx_done = 0;
      end
      a = next_addr(a, wrap);
    end
  endtask

  task automatic read_status(input logic [1:0] lm);
    logic [7:0] exp = {6'b0, m_udr, m_ovr};
    start_txn(lm);
    rx_data = 32'h05; rx_data_valid = 1; tick(); rx_data_valid = 0;
    chk("st_pad_dir", pad_dir, 1);
    tick();
    chk("st_byte", tx_data[DW-1 -: 8], exp);
    chk("st_tx_counter", tx_counter, 8 / lanes_of(lm) - 1);
    chk("st_valid", tx_data_valid, 1);
    tx_done = 1; tick(); tx_done = 0;
    chk("st_back_cmd", pad_dir, 0);
    m_ovr = 0; m_udr = 0;
  endtask

  initial begin
    #1 sys_rstn = 0;
    #2;
    chk("rst_rx_counter", rx_counter, 7);
    chk("rst_pad_dir", pad_dir, 0);
    chk("rst_pad_lanes", pad_lanes, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_counter", tx_counter, 0);
    chk("rst_addr", ctrl_addr, 0);
    chk("rst_err", cmd_error, 0);
    chk("rst_pulses", {tx_data_valid, tx_counter_upd, ctrl_addr_valid, ctrl_data_tx_ready, ctrl_rd_wr}, 0);
    tick(); sys_rstn = 1;

    run_burst(8'h02, 2'b00, 32'h100, 3, 16'd0, 8'd0, 8'h00);
    end_txn();
    run_burst(8'h0B, 2'b10, 32'h1C, 3, 16'd4, 8'd8, 8'h00);
    end_txn();
    run_burst(8'h03, 2'b00, 32'h200, 3, 16'd0, 8'd0, 8'b010);
    end_txn();
    read_status(2'b00);
    read_status(2'b00);

    start_txn(2'b01);
    rx_data = 32'h9F; rx_data_valid = 1; tick(); rx_data_valid = 0;
    chk("err_flag", cmd_error, 1);
    rx_data = 32'h02; rx_data_valid = 1; tick();
    rx_data = 32'h100; tick(); rx_data_valid = 0;
    chk("err_no_addr", ctrl_addr_valid, 0);
    chk("err_still", cmd_error, 1);
    cs = 1; tick(); cs = 0;
    chk("err_cleared", cmd_error, 0);
    chk("err_rx_counter", rx_counter, 3);

    run_burst(8'h02, 2'b00, 32'h300, 1, 16'd0, 8'd0, 8'h00);
    cs = 1; rx_data = 32'hDEAD; rx_data_valid = 1; #1;
    chk("csrx_no_strobe", ctrl_data_rx_valid, 0);
    chk("csrx_no_upd", rx_counter_upd, 0);
    tick(); rx_data_valid = 0;
    chk("csrx_addr", ctrl_addr, 0);
    chk("csrx_addr_valid", ctrl_addr_valid, 0);
    read_status(2'b00);

    run_burst(8'h03, 2'b10, 32'h40, 2, 16'd0, 8'd0, 8'h01);
    #2 sys_rstn = 0;
    #1;
    chk("arst_pad_dir", pad_dir, 0);
    chk("arst_tx_data", tx_data, 0);
    chk("arst_addr", ctrl_addr, 0);
    chk("arst_pad_lanes", pad_lanes, 0);
    chk("arst_rx_counter", rx_counter, 7);
    chk("arst_rd_wr", ctrl_rd_wr, 0);
    tick(); sys_rstn = 1; m_ovr = 0; m_udr = 0;
    read_status(2'b00);

    for (int i = 0; i < 24; i++) begin
      int r = $urandom_range(0, 2);
      run_burst(r == 0 ? 8'h02 : r == 1 ? 8'h03 : 8'h0B, 2'($urandom), $urandom,
                $urandom_range(1, 5), wraps[$urandom_range(0, 6)], 8'($urandom_range(0, 3)),
                8'($urandom & $urandom));
      end_txn();
      if (i % 4 == 3) read_status(2'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
endmodule
